// File: rtl/cvfpu_dispatch_rob.sv
//------------------------------------------------------------------------------
// Module   : cvfpu_dispatch_rob
// Brief    : Round-robin dispatch of FP requests to NUM_UNITS FPUs with an
//            in-order reorder buffer for results and user tags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cvfpu_dispatch_rob #(
    parameter int WIDTH     = 512,
    parameter int TAG_WIDTH = 1,
    parameter int NUM_UNITS = 2,
    parameter int ROB_DEPTH = 8,
    localparam int IDX_W    = $clog2(ROB_DEPTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3*WIDTH-1:0]         req_bits_operands,
    input  logic [31:0]                req_bits_ctrl,
    input  logic [TAG_WIDTH-1:0]       req_bits_tag,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH-1:0]           resp_bits_result,
    output logic [4:0]                 resp_bits_status,
    output logic [TAG_WIDTH-1:0]       resp_bits_tag,
    input  logic                       flush,
    output logic                       busy,
    output logic                       error,
    output logic [NUM_UNITS-1:0]       unit_req_valid,
    input  logic [NUM_UNITS-1:0]       unit_req_ready,
    output logic [3*WIDTH-1:0]         unit_req_operands,
    output logic [31:0]                unit_req_ctrl,
    output logic [IDX_W-1:0]           unit_req_tag,
    output logic                       unit_flush,
    input  logic [NUM_UNITS-1:0]       unit_resp_valid,
    output logic [NUM_UNITS-1:0]       unit_resp_ready,
    input  logic [NUM_UNITS*WIDTH-1:0] unit_resp_result,
    input  logic [NUM_UNITS*5-1:0]     unit_resp_status,
    input  logic [NUM_UNITS*IDX_W-1:0] unit_resp_tag
);

    localparam int RR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [RR_W:0] c_num_units = (RR_W+1)'(NUM_UNITS);

    logic [IDX_W:0]           r_head;
    logic [IDX_W:0]           r_tail;
    logic [ROB_DEPTH-1:0]     r_alloc;
    logic [ROB_DEPTH-1:0]     r_done;
    logic [RR_W-1:0]          r_rr;
    logic                     r_error;
    logic [WIDTH-1:0]         r_result [ROB_DEPTH];
    logic [4:0]               r_status [ROB_DEPTH];
    logic [TAG_WIDTH-1:0]     r_tag    [ROB_DEPTH];

    logic [IDX_W-1:0]         w_head_idx;
    logic [IDX_W-1:0]         w_tail_idx;
    logic                     w_full;
    logic                     w_fire;
    logic                     w_retire;
    logic [2*NUM_UNITS-1:0]   w_ready_rot;
    logic                     w_found;
    logic [RR_W-1:0]          w_off;
    logic [RR_W:0]            w_sum;
    logic [RR_W:0]            w_inc;
    logic [RR_W-1:0]          w_sel;
    logic [RR_W-1:0]          w_rr_next;
    logic [IDX_W-1:0]         w_wb_idx [NUM_UNITS];
    logic [NUM_UNITS-1:0]     w_wb_ok;
    logic [NUM_UNITS-1:0]     w_wb_err;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_full     = (r_head[IDX_W] != r_tail[IDX_W]) && (w_head_idx == w_tail_idx);

    // Full blocks new requests even if the head retires this cycle.
    assign req_ready  = !flush && !w_full && (|unit_req_ready);
    assign w_fire     = req_valid && req_ready;

    // Rotate the ready vector so bit 0 is the unit at the round-robin pointer.
    assign w_ready_rot = {unit_req_ready, unit_req_ready} >> r_rr;

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!w_found && w_ready_rot[k]) begin
                w_found = 1'b1;
                w_off   = RR_W'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_rr} + {1'b0, w_off};
    assign w_sel     = (w_sum >= c_num_units) ? RR_W'(w_sum - c_num_units) : RR_W'(w_sum);
    assign w_inc     = {1'b0, w_sel} + 1'b1;
    assign w_rr_next = (w_inc >= c_num_units) ? '0 : RR_W'(w_inc);

    assign unit_req_valid    = w_fire ? (NUM_UNITS'(1) << w_sel) : '0;
    assign unit_req_operands = req_bits_operands;
    assign unit_req_ctrl     = req_bits_ctrl;
    assign unit_req_tag      = w_tail_idx;
    assign unit_flush        = flush;
    assign unit_resp_ready   = '1;

    // Writebacks to a free or already-completed entry are dropped and flagged.
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_wb_idx[i] = unit_resp_tag[i*IDX_W +: IDX_W];
            w_wb_ok[i]  = unit_resp_valid[i] && !flush &&
                          r_alloc[w_wb_idx[i]] && !r_done[w_wb_idx[i]];
            w_wb_err[i] = unit_resp_valid[i] && !flush &&
                          !(r_alloc[w_wb_idx[i]] && !r_done[w_wb_idx[i]]);
        end
    end

    assign resp_valid       = r_alloc[w_head_idx] && r_done[w_head_idx];
    assign resp_bits_result = r_result[w_head_idx];
    assign resp_bits_status = r_status[w_head_idx];
    assign resp_bits_tag    = r_tag[w_head_idx];
    assign w_retire         = resp_valid && resp_ready;

    assign busy  = (r_head != r_tail);
    assign error = r_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_alloc <= '0;
            r_done  <= '0;
            r_rr    <= '0;
            r_error <= 1'b0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_alloc <= '0;
            r_done  <= '0;
        end else begin
            if (w_retire) begin
                r_alloc[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_wb_ok[i]) begin
                    r_done[w_wb_idx[i]] <= 1'b1;
                end
            end
            if (|w_wb_err) begin
                r_error <= 1'b1;
            end
            if (w_fire) begin
                r_alloc[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= 1'b0;
                r_tail              <= r_tail + 1'b1;
                r_rr                <= w_rr_next;
            end
        end
    end

    // Payload storage needs no reset; validity lives in the alloc/done bits.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_wb_ok[i]) begin
                r_result[w_wb_idx[i]] <= unit_resp_result[i*WIDTH +: WIDTH];
                r_status[w_wb_idx[i]] <= unit_resp_status[i*5 +: 5];
            end
        end
        if (w_fire) begin
            r_tag[w_tail_idx] <= req_bits_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cvfpu_dispatch_rob.sv
//------------------------------------------------------------------------------
// Module   : tb_cvfpu_dispatch_rob
// Brief    : Directed and randomized checks of cvfpu_dispatch_rob against an
//            in-order ROB reference model; the bench also plays the FPU units.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cvfpu_dispatch_rob;

    localparam int W  = 64;
    localparam int TW = 4;
    localparam int NU = 2;
    localparam int RD = 8;
    localparam int IW = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [3*W-1:0]    req_bits_operands;
    logic [31:0]       req_bits_ctrl;
    logic [TW-1:0]     req_bits_tag;
    logic              resp_valid;
    logic              resp_ready;
    logic [W-1:0]      resp_bits_result;
    logic [4:0]        resp_bits_status;
    logic [TW-1:0]     resp_bits_tag;
    logic              flush;
    logic              busy;
    logic              error;
    logic [NU-1:0]     unit_req_valid;
    logic [NU-1:0]     unit_req_ready;
    logic [3*W-1:0]    unit_req_operands;
    logic [31:0]       unit_req_ctrl;
    logic [IW-1:0]     unit_req_tag;
    logic              unit_flush;
    logic [NU-1:0]     unit_resp_valid;
    logic [NU-1:0]     unit_resp_ready;
    logic [NU*W-1:0]   unit_resp_result;
    logic [NU*5-1:0]   unit_resp_status;
    logic [NU*IW-1:0]  unit_resp_tag;

    always #5 clock = ~clock;

    cvfpu_dispatch_rob #(
        .WIDTH(W), .TAG_WIDTH(TW), .NUM_UNITS(NU), .ROB_DEPTH(RD)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bits_operands(req_bits_operands), .req_bits_ctrl(req_bits_ctrl),
        .req_bits_tag(req_bits_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_bits_result(resp_bits_result), .resp_bits_status(resp_bits_status),
        .resp_bits_tag(resp_bits_tag),
        .flush(flush), .busy(busy), .error(error),
        .unit_req_valid(unit_req_valid), .unit_req_ready(unit_req_ready),
        .unit_req_operands(unit_req_operands), .unit_req_ctrl(unit_req_ctrl),
        .unit_req_tag(unit_req_tag), .unit_flush(unit_flush),
        .unit_resp_valid(unit_resp_valid), .unit_resp_ready(unit_resp_ready),
        .unit_resp_result(unit_resp_result), .unit_resp_status(unit_resp_status),
        .unit_resp_tag(unit_resp_tag)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: requests numbered in order; ROB slot = number mod RD.
    int             hs, ts, rr_m;
    logic [TW-1:0]  m_tag [RD];
    logic [W-1:0]   m_res [RD];
    logic [4:0]     m_st  [RD];
    bit             m_done[RD];
    int             uq0[$];
    int             uq1[$];
    logic [TW-1:0]  obs_tag[$];
    logic [W-1:0]   obs_res[$];
    logic [4:0]     obs_st[$];

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        req_valid = 0; req_bits_operands = '0; req_bits_ctrl = '0; req_bits_tag = '0;
        resp_ready = 0; flush = 0; unit_req_ready = 2'b11; unit_resp_valid = '0;
        unit_resp_result = '0; unit_resp_status = '0; unit_resp_tag = '0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        hs = 0; ts = 0; rr_m = 0;
        foreach (m_done[i]) m_done[i] = 0;
        uq0.delete(); uq1.delete();
    endtask

    task automatic rand_ops;
        for (int k = 0; k < 3*W/32; k++) req_bits_operands[k*32 +: 32] = $urandom;
        req_bits_ctrl = $urandom;
    endtask

    // Presents one request for a cycle; the caller knows it must be accepted.
    task automatic issue(input logic [TW-1:0] tag, output logic [NU-1:0] uv, output logic [IW-1:0] ut);
        int idx;
        rand_ops();
        req_valid = 1; req_bits_tag = tag;
        #1;
        uv = unit_req_valid; ut = unit_req_tag;
        idx = ts % RD;
        m_tag[idx] = tag; m_res[idx] = {$urandom, $urandom}; m_st[idx] = 5'($urandom);
        m_done[idx] = 0; ts++;
        cyc();
        req_valid = 0;
    endtask

    task automatic wb(input logic [NU-1:0] v, input int i0, input int i1);
        unit_resp_valid  = v;
        unit_resp_tag    = {IW'(i1), IW'(i0)};
        unit_resp_result = {m_res[i1], m_res[i0]};
        unit_resp_status = {m_st[i1], m_st[i0]};
        cyc();
        unit_resp_valid = '0;
        if (v[0]) m_done[i0] = 1;
        if (v[1]) m_done[i1] = 1;
    endtask

    task automatic collect(input int n, output int got);
        got = 0;
        obs_tag.delete(); obs_res.delete(); obs_st.delete();
        resp_ready = 1;
        for (int c = 0; c < 20 + 4*n && got < n; c++) begin
            #1;
            if (resp_valid) begin
                obs_tag.push_back(resp_bits_tag);
                obs_res.push_back(resp_bits_result);
                obs_st.push_back(resp_bits_status);
                got++;
            end
            cyc();
        end
        resp_ready = 0;
    endtask

    task automatic test_reset;
        logic [3*W-1:0] ops;
        do_reset();
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (unit_req_valid !== 2'b00) begin errors++; $display("FAIL reset_unit_req_valid: got %b want 00", unit_req_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (unit_resp_ready !== 2'b11) begin errors++; $display("FAIL unit_resp_ready: got %b want 11", unit_resp_ready); end
        rand_ops();
        ops = req_bits_operands;
        #1;
        checks++; if (unit_req_operands !== ops) begin errors++; $display("FAIL operand_broadcast: got %h want %h", unit_req_operands, ops); end
        cyc();
    endtask

    task automatic test_back_to_back;
        logic [NU-1:0] uv; logic [IW-1:0] ut; int got, idx;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(TW'(i), uv, ut);
            checks++; if (uv !== NU'(1 << (i % 2))) begin errors++; $display("FAIL b2b_unit[%0d]: got %b want %b", i, uv, NU'(1 << (i % 2))); end
            checks++; if (ut !== IW'(i)) begin errors++; $display("FAIL b2b_unit_tag[%0d]: got %0d want %0d", i, ut, i); end
        end
        wb(2'b11, 0, 1);
        wb(2'b11, 2, 3);
        collect(4, got);
        checks++; if (got != 4) begin errors++; $display("FAIL b2b_resp_count: got %0d want 4", got); end
        for (int k = 0; k < got; k++) begin
            idx = (hs + k) % RD;
            checks++; if (obs_tag[k] !== TW'(k)) begin errors++; $display("FAIL b2b_resp_tag[%0d]: got %0d want %0d", k, obs_tag[k], k); end
            checks++; if (obs_res[k] !== m_res[idx] || obs_st[k] !== m_st[idx]) begin errors++; $display("FAIL b2b_resp_data[%0d]: got %h/%h want %h/%h", k, obs_res[k], obs_st[k], m_res[idx], m_st[idx]); end
        end
        hs += got;
    endtask

    task automatic test_out_of_order;
        logic [NU-1:0] uv; logic [IW-1:0] ut;
        do_reset();
        issue(4'd5, uv, ut);
        checks++; if (uv !== 2'b01 || ut !== 3'd0) begin errors++; $display("FAIL ooo_dispatch_a: got %b/%0d want 01/0", uv, ut); end
        issue(4'd6, uv, ut);
        checks++; if (uv !== 2'b10 || ut !== 3'd1) begin errors++; $display("FAIL ooo_dispatch_b: got %b/%0d want 10/1", uv, ut); end
        resp_ready = 1;
        wb(2'b10, 0, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ooo_hold[%0d]: got %b want 0", c, resp_valid); end
            cyc();
        end
        wb(2'b01, 0, 0);
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_bits_tag !== 4'd5 || resp_bits_result !== m_res[0]) begin errors++; $display("FAIL ooo_resp_a: got v=%b tag=%0d res=%h want v=1 tag=5 res=%h", resp_valid, resp_bits_tag, resp_bits_result, m_res[0]); end
        cyc();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_bits_tag !== 4'd6 || resp_bits_result !== m_res[1]) begin errors++; $display("FAIL ooo_resp_b: got v=%b tag=%0d res=%h want v=1 tag=6 res=%h", resp_valid, resp_bits_tag, resp_bits_result, m_res[1]); end
        cyc();
        #1;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ooo_empty: got v=%b busy=%b want 0/0", resp_valid, busy); end
        resp_ready = 0;
        hs += 2;
    endtask

    task automatic test_full;
        logic [NU-1:0] uv; logic [IW-1:0] ut; int perm[RD]; int j, t, p, got, idx;
        do_reset();
        for (int i = 0; i < RD; i++) begin
            issue(TW'($urandom), uv, ut);
            checks++; if (ut !== IW'(i)) begin errors++; $display("FAIL full_unit_tag[%0d]: got %0d want %0d", i, ut, i); end
        end
        #1;
        checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_state: got ready=%b busy=%b want 0/1", req_ready, busy); end
        for (int i = 0; i < RD; i++) perm[i] = i;
        for (int i = RD-1; i > 0; i--) begin
            j = $urandom_range(0, i); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int k = 0; k < RD; k++) begin
            p = perm[k];
            if (p % 2 == 0) wb(2'b01, p, 0); else wb(2'b10, 0, p);
        end
        #1;
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin errors++; $display("FAIL full_no_bypass: got ready=%b resp_valid=%b want 0/1", req_ready, resp_valid); end
        collect(RD, got);
        checks++; if (got != RD) begin errors++; $display("FAIL full_resp_count: got %0d want %0d", got, RD); end
        for (int k = 0; k < got; k++) begin
            idx = (hs + k) % RD;
            checks++; if (obs_tag[k] !== m_tag[idx] || obs_res[k] !== m_res[idx] || obs_st[k] !== m_st[idx]) begin errors++; $display("FAIL full_resp[%0d]: got %0d/%h/%h want %0d/%h/%h", k, obs_tag[k], obs_res[k], obs_st[k], m_tag[idx], m_res[idx], m_st[idx]); end
        end
        hs += got;
    endtask

    task automatic test_rr_ready;
        logic [NU-1:0] uv; logic [IW-1:0] ut;
        do_reset();
        unit_req_ready = 2'b10;
        issue(4'd1, uv, ut);
        checks++; if (uv !== 2'b10 || ut !== 3'd0) begin errors++; $display("FAIL rr_skip: got %b/%0d want 10/0", uv, ut); end
        unit_req_ready = 2'b11;
        issue(4'd2, uv, ut);
        checks++; if (uv !== 2'b01) begin errors++; $display("FAIL rr_wrap: got %b want 01", uv); end
        unit_req_ready = 2'b00;
        req_valid = 1;
        #1;
        checks++; if (req_ready !== 1'b0 || unit_req_valid !== 2'b00) begin errors++; $display("FAIL rr_none_ready: got ready=%b uv=%b want 0/00", req_ready, unit_req_valid); end
        cyc();
        req_valid = 0;
        unit_req_ready = 2'b11;
    endtask

    task automatic test_flush;
        logic [NU-1:0] uv; logic [IW-1:0] ut; int got;
        do_reset();
        for (int i = 0; i < 3; i++) issue(TW'(i), uv, ut);
        flush = 1; req_valid = 1;
        unit_resp_valid = 2'b01; unit_resp_tag = '0;
        #1;
        checks++; if (req_ready !== 1'b0 || unit_req_valid !== 2'b00 || unit_flush !== 1'b1) begin errors++; $display("FAIL flush_cycle: got ready=%b uv=%b uflush=%b want 0/00/1", req_ready, unit_req_valid, unit_flush); end
        cyc();
        flush = 0; req_valid = 0; unit_resp_valid = '0;
        hs = 0; ts = 0;
        foreach (m_done[i]) m_done[i] = 0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL flush_after: got busy=%b rv=%b err=%b want 0/0/0", busy, resp_valid, error); end
        issue(4'd9, uv, ut);
        checks++; if (ut !== 3'd0 || uv !== 2'b10) begin errors++; $display("FAIL flush_next_dispatch: got %b/%0d want 10/0", uv, ut); end
        wb(2'b10, 0, 0);
        collect(1, got);
        checks++; if (got != 1 || obs_tag[0] !== 4'd9 || obs_res[0] !== m_res[0]) begin errors++; $display("FAIL flush_resp: got n=%0d want 1 tag 9", got); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL flush_error: got %b want 0", error); end
        hs += got;
    endtask

    task automatic test_bad_tag;
        logic [NU-1:0] uv; logic [IW-1:0] ut; int got;
        do_reset();
        issue(4'd3, uv, ut);
        unit_resp_valid = 2'b01; unit_resp_tag = {3'd0, 3'd5};
        unit_resp_result = {W'(0), W'(64'hdead)}; unit_resp_status = 10'h1f;
        cyc();
        unit_resp_valid = '0;
        #1;
        checks++; if (error !== 1'b1 || busy !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bad_tag: got err=%b busy=%b rv=%b want 1/1/0", error, busy, resp_valid); end
        wb(2'b01, 0, 0);
        collect(1, got);
        checks++; if (got != 1 || obs_tag[0] !== 4'd3 || obs_res[0] !== m_res[0] || obs_st[0] !== m_st[0]) begin errors++; $display("FAIL bad_tag_resp: got n=%0d want 1 tag 3 res %h", got, m_res[0]); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b want 1", error); end
        hs += got;
    endtask

    task automatic test_random;
        logic [NU-1:0] rdy, exp_uv;
        bit wb0, wb1, fire, rv, exp_rdy;
        int i0, i1, sel, idx;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rdy = NU'($urandom); unit_req_ready = rdy;
            req_valid = ($urandom_range(0, 3) != 0);
            rand_ops();
            req_bits_tag = TW'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            wb0 = 0; wb1 = 0; i0 = 0; i1 = 0;
            if (uq0.size() > 0 && $urandom_range(0, 1) == 1) begin i0 = uq0.pop_front(); wb0 = 1; end
            if (uq1.size() > 0 && $urandom_range(0, 1) == 1) begin i1 = uq1.pop_front(); wb1 = 1; end
            unit_resp_valid  = {wb1, wb0};
            unit_resp_tag    = {IW'(i1), IW'(i0)};
            unit_resp_result = {m_res[i1], m_res[i0]};
            unit_resp_status = {m_st[i1], m_st[i0]};
            #1;
            exp_rdy = (ts - hs < RD) && (rdy != 0);
            fire = req_valid && exp_rdy;
            sel = -1;
            for (int k = 0; k < NU; k++) if (sel < 0 && rdy[(rr_m + k) % NU]) sel = (rr_m + k) % NU;
            if (fire) exp_uv = NU'(1 << sel); else exp_uv = '0;
            rv = (ts > hs) && m_done[hs % RD];
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_req_ready@%0d: got %b want %b", c, req_ready, exp_rdy); end
            checks++; if (unit_req_valid !== exp_uv) begin errors++; $display("FAIL rnd_unit_req_valid@%0d: got %b want %b", c, unit_req_valid, exp_uv); end
            if (fire) begin
                checks++; if (unit_req_tag !== IW'(ts % RD)) begin errors++; $display("FAIL rnd_unit_req_tag@%0d: got %0d want %0d", c, unit_req_tag, ts % RD); end
            end
            checks++; if (resp_valid !== rv) begin errors++; $display("FAIL rnd_resp_valid@%0d: got %b want %b", c, resp_valid, rv); end
            if (rv) begin
                idx = hs % RD;
                checks++; if (resp_bits_tag !== m_tag[idx] || resp_bits_result !== m_res[idx] || resp_bits_status !== m_st[idx]) begin errors++; $display("FAIL rnd_resp_data@%0d: got %0d/%h/%h want %0d/%h/%h", c, resp_bits_tag, resp_bits_result, resp_bits_status, m_tag[idx], m_res[idx], m_st[idx]); end
            end
            checks++; if (busy !== (ts != hs)) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, ts != hs); end
            if (wb0) m_done[i0] = 1;
            if (wb1) m_done[i1] = 1;
            if (rv && resp_ready) begin m_done[hs % RD] = 0; hs++; end
            if (fire) begin
                idx = ts % RD;
                m_tag[idx] = req_bits_tag; m_res[idx] = {$urandom, $urandom};
                m_st[idx] = 5'($urandom); m_done[idx] = 0;
                if (sel == 0) uq0.push_back(idx); else uq1.push_back(idx);
                rr_m = (sel + 1) % NU;
                ts++;
            end
            cyc();
        end
        idle();
        #1;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rnd_error: got %b want 0", error); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_out_of_order();
        test_full();
        test_rr_ready();
        test_flush();
        test_bad_tag();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
